// File: rtl/tx_fifo_drain.sv
// tx_fifo_drain: read side of the TX register FIFO. Pops beats, polices
// SOP/EOP framing and hands beats to the PCIe TX stream through a 2-entry
// skid buffer so fifoPop never depends combinationally on txReady.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | between packets; only a SOP word may start a packet
// ST_XFER | inside a packet; every head word is forwarded until EOP
module tx_fifo_drain #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                           clockCore,
    input  logic                           resetCore,
    input  logic                           enable,
    input  logic                           fifoEmpty,
    input  logic [DATA_W+KEEP_W+2:0]       fifoDataOut,
    output logic                           fifoPop,
    output logic                           txValid,
    input  logic                           txReady,
    output logic [DATA_W-1:0]              txData,
    output logic [KEEP_W-1:0]              txKeep,
    output logic                           txSop,
    output logic                           txEop,
    output logic                           txErr,
    output logic                           framingError,
    output logic [CNT_W-1:0]               pktCount,
    output logic                           idle
);

    localparam int WORD_W = DATA_W + KEEP_W + 3;
    localparam int SOP_B  = DATA_W + KEEP_W;
    localparam int EOP_B  = SOP_B + 1;
    localparam int ERR_B  = SOP_B + 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WORD_W-1:0]   r_ent0;
    logic [WORD_W-1:0]   r_ent1;
    logic [1:0]          r_occ;
    logic [1:0]          w_occ_nxt;
    logic                r_idle;
    logic [CNT_W-1:0]    r_pkt_cnt;

    logic                w_head_sop;
    logic                w_head_eop;
    logic                w_has_room;
    logic                w_drop;
    logic                w_accept;
    logic                w_restart;
    logic                w_wr;
    logic                w_rd;
    logic [WORD_W-1:0]   w_new;

    assign w_head_sop = fifoDataOut[SOP_B];
    assign w_head_eop = fifoDataOut[EOP_B];
    assign w_has_room = (r_occ < 2'd2);

    // A SOP arriving while a packet is still open is forwarded as poisoned.
    assign w_new = {fifoDataOut[ERR_B] | w_restart, fifoDataOut[EOP_B:0]};

    // Input FSM state register.
    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Input FSM next-state: only words actually written to the buffer move the FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_head_eop) w_state_nxt = ST_XFER;
            ST_XFER: if (w_accept && w_head_eop)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Input FSM outputs: drop stray non-SOP words in IDLE, otherwise pop only into free buffer space.
    always_comb begin
        w_drop    = 1'b0;
        w_accept  = 1'b0;
        w_restart = 1'b0;
        if (!fifoEmpty) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_head_sop) begin
                        w_drop = 1'b1;
                    end else if (enable && w_has_room) begin
                        w_accept = 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_has_room) begin
                        w_accept  = 1'b1;
                        w_restart = w_head_sop;
                    end
                end
                default: begin
                    w_accept = 1'b0;
                end
            endcase
        end
    end

    assign fifoPop      = resetCore & (w_drop | w_accept);
    assign framingError = resetCore & (w_drop | w_restart);

    assign w_wr = w_accept;
    assign w_rd = (r_occ != 2'd0) && txReady;

    // Occupancy after this edge; simultaneous write and read cancel.
    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_wr, w_rd})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Skid buffer: entry 0 is always the head that drives the tx* outputs.
    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_rd) begin
                if (w_wr && (r_occ == 2'd1)) begin
                    r_ent0 <= w_new;
                end else begin
                    r_ent0 <= r_ent1;
                end
                if (w_wr && (r_occ == 2'd2)) begin
                    r_ent1 <= w_new;
                end
            end else if (w_wr) begin
                if (r_occ == 2'd0) begin
                    r_ent0 <= w_new;
                end else begin
                    r_ent1 <= w_new;
                end
            end
        end
    end

    // Registered idle flag reflecting FSM and buffer state after the edge.
    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= (w_state_nxt == ST_IDLE) && (w_occ_nxt == 2'd0);
        end
    end

    // Completed-packet counter, advanced when an EOP beat leaves the buffer.
    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            r_pkt_cnt <= '0;
        end else if (w_rd && r_ent0[EOP_B]) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign txValid  = (r_occ != 2'd0);
    assign txData   = r_ent0[DATA_W-1:0];
    assign txKeep   = r_ent0[SOP_B-1:DATA_W];
    assign txSop    = r_ent0[SOP_B];
    assign txEop    = r_ent0[EOP_B];
    assign txErr    = r_ent0[ERR_B];
    assign pktCount = r_pkt_cnt;
    assign idle     = r_idle;

endmodule

// File: tb/tb_tx_fifo_drain.sv
// Bench for tx_fifo_drain: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a queue-based model of the drain stage.
module tb_tx_fifo_drain;

    localparam int DATA_W = 256;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 4;
    localparam int WORD_W = DATA_W + KEEP_W + 3;

    typedef logic [WORD_W-1:0] word_t;

    logic               clockCore;
    logic               resetCore;
    logic               enable;
    logic               fifoEmpty;
    word_t              fifoDataOut;
    logic               fifoPop;
    logic               txValid;
    logic               txReady;
    logic [DATA_W-1:0]  txData;
    logic [KEEP_W-1:0]  txKeep;
    logic               txSop;
    logic               txEop;
    logic               txErr;
    logic               framingError;
    logic [CNT_W-1:0]   pktCount;
    logic               idle;

    tx_fifo_drain #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clockCore    (clockCore),
        .resetCore    (resetCore),
        .enable       (enable),
        .fifoEmpty    (fifoEmpty),
        .fifoDataOut  (fifoDataOut),
        .fifoPop      (fifoPop),
        .txValid      (txValid),
        .txReady      (txReady),
        .txData       (txData),
        .txKeep       (txKeep),
        .txSop        (txSop),
        .txEop        (txEop),
        .txErr        (txErr),
        .framingError (framingError),
        .pktCount     (pktCount),
        .idle         (idle)
    );

    initial clockCore = 1'b0;
    always #5 clockCore = ~clockCore;

    // Model state: FIFO contents, skid contents, packet-open flag, packet count.
    word_t        src_q[$];
    word_t        skid_q[$];
    bit           m_in_pkt;
    int unsigned  m_pkt;
    int           n_pass;
    int           n_total;

    task automatic check_val(input string tag, input word_t obs, input word_t exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic word_t mk_word(input bit sop, input bit eop, input bit err);
        word_t w;
        w = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        w[DATA_W +: KEEP_W]   = KEEP_W'($urandom_range(0, 255));
        w[DATA_W + KEEP_W]     = sop;
        w[DATA_W + KEEP_W + 1] = eop;
        w[DATA_W + KEEP_W + 2] = err;
        return w;
    endfunction

    task automatic add_packet(input int beats, input bit err);
        for (int b = 0; b < beats; b++) begin
            src_q.push_back(mk_word(b == 0, b == beats - 1, err && (b == beats - 1)));
        end
    endtask

    task automatic add_junk();
        src_q.push_back(mk_word(1'b0, 1'($urandom_range(0, 1)), 1'b0));
    endtask

    // SOP, then a second SOP before any EOP, optionally followed by more beats.
    task automatic add_restart(input int tail);
        src_q.push_back(mk_word(1'b1, 1'b0, 1'b0));
        src_q.push_back(mk_word(1'b1, tail == 0, 1'b0));
        for (int b = 0; b < tail; b++) begin
            src_q.push_back(mk_word(1'b0, b == tail - 1, 1'b0));
        end
    endtask

    // One clock cycle: drive at negedge, check after settling, update model at posedge.
    task automatic cycle(input bit rst_n, input bit en, input bit rdy, input bit gap);
        bit     avail;
        word_t  head;
        int     occ;
        bit     drop;
        bit     accept;
        bit     restart;
        bit     xfer;
        word_t  wr_word;

        resetCore   = rst_n;
        enable      = en;
        txReady     = rdy;
        avail       = (src_q.size() > 0) && !gap;
        fifoEmpty   = !avail;
        head        = (src_q.size() > 0) ? src_q[0] : mk_word(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        fifoDataOut = head;
        #1;

        occ     = skid_q.size();
        drop    = avail && !m_in_pkt && !head[DATA_W + KEEP_W];
        accept  = avail && (occ < 2) && (m_in_pkt || (head[DATA_W + KEEP_W] && en));
        restart = accept && m_in_pkt && head[DATA_W + KEEP_W];
        xfer    = (occ > 0) && rdy;

        check_val("fifoPop",      WORD_W'(fifoPop),      WORD_W'(rst_n && (drop || accept)));
        check_val("framingError", WORD_W'(framingError), WORD_W'(rst_n && (drop || restart)));
        check_val("txValid",      WORD_W'(txValid),      WORD_W'(occ > 0));
        check_val("idle",         WORD_W'(idle),         WORD_W'(!m_in_pkt && (occ == 0)));
        check_val("pktCount",     WORD_W'(pktCount),     WORD_W'(m_pkt));
        if (occ > 0) begin
            check_val("beat", {txErr, txEop, txSop, txKeep, txData}, skid_q[0]);
        end

        @(posedge clockCore);
        if (!rst_n) begin
            skid_q.delete();
            m_in_pkt = 1'b0;
            m_pkt    = 0;
        end else begin
            if (xfer) begin
                if (skid_q[0][DATA_W + KEEP_W + 1]) begin
                    m_pkt = (m_pkt + 1) % (1 << CNT_W);
                end
                void'(skid_q.pop_front());
            end
            if (drop || accept) begin
                void'(src_q.pop_front());
            end
            if (accept) begin
                wr_word = head;
                if (restart) begin
                    wr_word[DATA_W + KEEP_W + 2] = 1'b1;
                end
                skid_q.push_back(wr_word);
                m_in_pkt = !head[DATA_W + KEEP_W + 1];
            end
        end
        @(negedge clockCore);
    endtask

    task automatic run(input int n, input bit en, input bit rdy);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, en, rdy, 1'b0);
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        m_in_pkt    = 1'b0;
        m_pkt       = 0;
        resetCore   = 1'b0;
        enable      = 1'b0;
        txReady     = 1'b0;
        fifoEmpty   = 1'b1;
        fifoDataOut = '0;

        @(posedge clockCore);
        @(negedge clockCore);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Single 3-beat packet, downstream always ready.
        add_packet(3, 1'b0);
        run(6, 1'b1, 1'b1);

        // Same packet shape with a 4-cycle downstream stall after the first pop.
        add_packet(3, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        run(4, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);

        // Stray non-SOP word in IDLE.
        add_junk();
        run(3, 1'b1, 1'b1);

        // SOP followed by SOP+EOP.
        add_restart(0);
        run(5, 1'b1, 1'b1);

        // SOP held at the head while disabled, then released.
        add_packet(2, 1'b0);
        run(6, 1'b0, 1'b1);
        run(5, 1'b1, 1'b1);

        // Reset pulse mid-packet with a full buffer, then a clean packet.
        add_packet(6, 1'b0);
        run(3, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run(8, 1'b1, 1'b1);
        add_packet(2, 1'b1);
        run(5, 1'b1, 1'b1);

        // Randomized traffic: gaps, backpressure, enable toggles, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if (src_q.size() < 4) begin
                case ($urandom_range(0, 9))
                    0:       add_junk();
                    1:       add_restart($urandom_range(0, 2));
                    2:       add_packet($urandom_range(1, 5), 1'b1);
                    default: add_packet($urandom_range(1, 5), 1'b0);
                endcase
            end
            cycle($urandom_range(0, 299) != 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0);
        end

        run(40, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
